// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one cache read in flight and
// queues returned instructions with their PCs for decode; redirects flush the queue.
module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] ic_addr,
  output logic        ic_rd,
  input  logic [31:0] ic_data,
  input  logic        ic_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        dec_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [15:0] inst_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   FULL_X = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [15:0]   req_addr;
  logic [15:0]   next_pc;
  logic          rd_q;
  logic [31:0]   mem_inst [DEPTH];
  logic [15:0]   mem_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [15:0]   redir_a;
  logic          pop;
  logic          push;
  logic          room;
  logic [CW:0]   count_after;
  logic          issue;
  logic [15:0]   issue_a;

  assign redir_a    = redirect_pc & 16'hFFFC;
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign ic_addr    = req_addr;
  assign ic_rd      = rd_q;

  assign pop         = inst_valid && dec_ready;
  assign push        = (state == FETCH) && ic_ready && !redirect;
  assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  // A new request goes out only when its result is guaranteed a FIFO slot.
  assign room        = count_after < FULL_X;

  always_comb begin
    issue   = 1'b0;
    issue_a = next_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          issue   = 1'b1;
          issue_a = redir_a;
        end else if (room) begin
          issue = 1'b1;
        end
      end
      FETCH: begin
        if (ic_ready) begin
          if (redirect) begin
            issue   = 1'b1;
            issue_a = redir_a;
          end else if (room) begin
            issue = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (ic_ready) begin
          issue = 1'b1;
          if (redirect) issue_a = redir_a;
        end
      end
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= RESET_PC;
      next_pc  <= RESET_PC;
      rd_q     <= 1'b0;
    end else if (issue) begin
      state    <= FETCH;
      req_addr <= issue_a;
      next_pc  <= issue_a + 16'd4;
      rd_q     <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (ic_ready) begin
            state <= IDLE;
            rd_q  <= 1'b0;
          end else if (redirect) begin
            // In-flight read cannot be cancelled; remember the target and drop its data.
            next_pc <= redir_a;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) next_pc <= redir_a;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= ic_data;
        mem_pc[wr_ptr]   <= req_addr;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_after[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && count == FULL));
  end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a behavioural cache (hit=2 cycles, miss=3) plus a PC/instruction
// scoreboard fed by each scenario and drained as decode pops the FIFO.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ic_addr;
  logic        ic_rd;
  logic [31:0] ic_data;
  logic        ic_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [15:0] inst_pc;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] sb_e;
  bit          miss_all;
  bit          miss_one;
  logic [15:0] miss_addr;
  int          age;
  logic [15:0] req_a;

  typedef struct {
    logic [15:0] tgt;
    bit          miss;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t vecs[4];

  ifetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ic_addr(ic_addr), .ic_rd(ic_rd), .ic_data(ic_data),
    .ic_ready(ic_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit dr, input bit miss);
    rst       = 1'b1;
    redirect  = 1'b0;
    dec_ready = dr;
    miss_all  = miss;
    miss_one  = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Cache model: latches the address of a new read, checks it is held, answers after latency.
  always @(negedge clk) begin
    if (rst) begin
      ic_ready = 1'b0;
      ic_data  = 32'hDEADBEEF;
      age      = 0;
    end else begin
      if (ic_ready) begin
        ic_ready = 1'b0;
        ic_data  = 32'hDEADBEEF;
        age      = 0;
      end
      if (age > 0) chk("ic_hold", {15'd0, ic_rd, ic_addr}, {15'd0, 1'b1, req_a});
      else if (ic_rd) req_a = ic_addr;
      if (ic_rd || age > 0) begin
        age++;
        if (age >= ((miss_all || (miss_one && req_a == miss_addr)) ? 3 : 2)) begin
          ic_ready = 1'b1;
          ic_data  = 32'h00000013 + {16'd0, req_a};
        end
      end
    end
  end

  // Scoreboard: every decode pop while expectations are queued is compared.
  always @(negedge clk) begin
    if (!rst && inst_valid && dec_ready && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_pc", {16'd0, inst_pc}, {16'd0, sb_e});
      chk("sb_inst", inst, 32'h00000013 + {16'd0, sb_e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{tgt: 16'h0101, miss: 1'b0, e0: 16'h0100, e1: 16'h0104};
    vecs[1] = '{tgt: 16'hFFFC, miss: 1'b0, e0: 16'hFFFC, e1: 16'h0000};
    vecs[2] = '{tgt: 16'h1236, miss: 1'b1, e0: 16'h1234, e1: 16'h1238};
    vecs[3] = '{tgt: 16'hFFFE, miss: 1'b1, e0: 16'hFFFC, e1: 16'h0000};

    redirect = 1'b0; redirect_pc = 16'h0000; dec_ready = 1'b1;
    miss_all = 1'b0; miss_one = 1'b0; miss_addr = 16'h0000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ic_rd", {31'd0, ic_rd}, 32'd0);
    chk("rst_ic_addr", {16'd0, ic_addr}, 32'h0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", {16'd0, inst_pc}, 32'd0);

    // Hit stream from reset with decode always ready.
    do_reset(1'b1, 1'b0);
    exp_q = '{16'h0000, 16'h0004, 16'h0008};
    tick(); chk("t1_c1_rd", {31'd0, ic_rd}, 32'd1); chk("t1_c1_addr", {16'd0, ic_addr}, 32'h0);
    tick(); chk("t1_c2_valid", {31'd0, inst_valid}, 32'd0);
    tick(); chk("t1_c3_valid", {31'd0, inst_valid}, 32'd1); chk("t1_c3_pc", {16'd0, inst_pc}, 32'h0);
    tick(); chk("t1_c4_valid", {31'd0, inst_valid}, 32'd0);
    tick(); chk("t1_c5_pc", {16'd0, inst_pc}, 32'h4);
    tick(); tick(); chk("t1_c7_pc", {16'd0, inst_pc}, 32'h8);
    tick(); chk("t1_q_empty", exp_q.size(), 32'd0);

    // Decode stalled: FIFO fills and fetch stops until the first pop.
    do_reset(1'b0, 1'b0);
    repeat (5) tick();
    chk("t2_c5_rd", {31'd0, ic_rd}, 32'd0); chk("t2_c5_pc", {16'd0, inst_pc}, 32'h0);
    tick();
    chk("t2_c6_rd", {31'd0, ic_rd}, 32'd0); chk("t2_c6_valid", {31'd0, inst_valid}, 32'd1);
    exp_q = '{16'h0000, 16'h0004, 16'h0008};
    dec_ready = 1'b1;
    tick();
    chk("t2_c7_rd", {31'd0, ic_rd}, 32'd1); chk("t2_c7_addr", {16'd0, ic_addr}, 32'h8);
    chk("t2_c7_pc", {16'd0, inst_pc}, 32'h4);
    repeat (3) tick(); chk("t2_q_empty", exp_q.size(), 32'd0);

    // Redirect during a miss: flush now, drain the miss, then fetch the target.
    do_reset(1'b0, 1'b0);
    miss_one = 1'b1; miss_addr = 16'h0008;
    repeat (4) tick();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t3_c5_addr", {16'd0, ic_addr}, 32'h8); chk("t3_c5_pc", {16'd0, inst_pc}, 32'h4);
    redirect = 1'b1; redirect_pc = 16'h0101;
    tick();
    redirect = 1'b0;
    chk("t3_c6_valid", {31'd0, inst_valid}, 32'd0); chk("t3_c6_addr", {16'd0, ic_addr}, 32'h8);
    exp_q = '{16'h0100};
    dec_ready = 1'b1;
    tick(); tick();
    chk("t3_c8_addr", {16'd0, ic_addr}, 32'h0100); chk("t3_c8_valid", {31'd0, inst_valid}, 32'd0);
    tick(); tick();
    chk("t3_c10_pc", {16'd0, inst_pc}, 32'h0100);
    tick(); chk("t3_q_empty", exp_q.size(), 32'd0);

    // Redirect in the same cycle as the data for 0x000C.
    do_reset(1'b1, 1'b0);
    exp_q = '{16'h0000, 16'h0004, 16'h0008, 16'h0200};
    repeat (8) tick();
    chk("t4_c8_addr", {16'd0, ic_addr}, 32'h000C);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    chk("t4_c9_valid", {31'd0, inst_valid}, 32'd0); chk("t4_c9_addr", {16'd0, ic_addr}, 32'h0200);
    tick(); tick();
    chk("t4_c11_pc", {16'd0, inst_pc}, 32'h0200);
    tick(); chk("t4_q_empty", exp_q.size(), 32'd0);

    // Two redirects while draining a miss: only the last one is fetched.
    do_reset(1'b1, 1'b1);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0300;
    tick();
    redirect_pc = 16'h0400;
    chk("t5_c2_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("t5_c3_addr", {16'd0, ic_addr}, 32'h0);
    exp_q = '{16'h0400};
    tick(); chk("t5_c4_addr", {16'd0, ic_addr}, 32'h0400);
    repeat (3) tick();
    chk("t5_c7_pc", {16'd0, inst_pc}, 32'h0400);
    tick(); chk("t5_q_empty", exp_q.size(), 32'd0);

    // Table of redirect targets, including wrap past 0xFFFC and unaligned targets.
    do_reset(1'b1, 1'b0);
    repeat (3) tick();
    for (int v = 0; v < 4; v++) begin
      miss_all = vecs[v].miss;
      redirect = 1'b1; redirect_pc = vecs[v].tgt;
      tick();
      redirect = 1'b0;
      chk("vec_flush", {31'd0, inst_valid}, 32'd0);
      exp_q = '{vecs[v].e0, vecs[v].e1};
      repeat (14) tick();
      chk("vec_q_empty", exp_q.size(), 32'd0);
    end

    // Reset asserted mid-miss.
    do_reset(1'b0, 1'b1);
    repeat (5) tick();
    chk("t6_pre_rd", {31'd0, ic_rd}, 32'd1); chk("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rd", {31'd0, ic_rd}, 32'd0); chk("t6_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_addr", {16'd0, ic_addr}, 32'h0); chk("t6_inst", inst, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_restart_rd", {31'd0, ic_rd}, 32'd1); chk("t6_restart_addr", {16'd0, ic_addr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
